rtc_edit_ctrl: RTL
==================

Name: rtc_edit_ctrl

Overview:
Sequences user editing of the RTC time/date registers. Reads each field over the RTC bus, applies up/down button adjustments with BCD, per-field range wrap-around, and writes the result back. Sits between the button debouncers and the RTC bus master. Exposes the working value and selected field to the VGA display path.

Parameters:
BASE_ADDR, 8'h21, RTC bus address of field 0; field n is at BASE_ADDR+n.
TIMEOUT_CYCLES, 1000000000, idle cycles before auto-exit; used only with RTC_EDIT_TIMEOUT_EN.
CNT_W, 30, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
edit_req  in  1  single-cycle pulse; enters or leaves edit mode
btn_next  in  1  pulse; commits the current field, then selects the next field
btn_up  in  1  pulse; increments the working value
btn_down  in  1  pulse; decrements the working value
bus_req  out  1  bus request; held high until bus_ack
bus_we  out  1  1 = write, 0 = read; stable while bus_req is high
bus_addr  out  8  register address; stable while bus_req is high
bus_wdata  out  8  write data, BCD
bus_rdata  in  8  read data; valid in the bus_ack cycle
bus_ack  in  1  single-cycle completion
edit_active  out  1  high in every state except IDLE
field_sel  out  3  0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year
edit_val  out  8  working BCD value, for display

Behaviour:
- Reset values: all outputs 0. State = IDLE, field_sel = 0, edit_val = 8'h00, pending flags cleared.
- States and transitions:
  - IDLE: edit_req -> LOAD with field_sel = 0.
  - LOAD: bus_req=1, bus_we=0, bus_addr=BASE_ADDR+field_sel. On bus_ack, edit_val <= sanitised bus_rdata, then -> EDIT.
  - EDIT:
    - btn_up XOR btn_down adjusts edit_val; the value is updated on the next clock.
    - btn_up and btn_down in the same cycle: no change.
    - btn_next -> WRITE with next_after = LOAD.
    - edit_req -> WRITE with next_after = IDLE.
    - edit_req and btn_next in the same cycle: edit_req wins.
  - WRITE: bus_req=1, bus_we=1, bus_wdata=edit_val. On bus_ack:
    - if next_after = LOAD, field_sel <= (field_sel==5) ? 0 : field_sel+1, then -> LOAD;
    - otherwise -> IDLE.
- Latency:
  - bus_req rises the cycle after the triggering pulse.
  - bus_req falls the cycle after bus_ack.
  - An up/down pulse is visible on edit_val one cycle later.
- Field ranges (BCD):
  - sec 00-59, min 00-59, hour 00-23, day 01-31, month 01-12, year 00-99.
  - Up at max -> min; down at min -> max.
  - Units carry: x9 + 1 -> (x+1)0. Borrow: x0 - 1 -> (x-1)9.
- Sanitising reads: a read value with any nibble > 9, or outside the field range, loads as the field minimum.
- Events outside EDIT:
  - btn_up, btn_down and btn_next are ignored outside EDIT.
  - edit_req during LOAD/WRITE sets pend_exit. The controller then goes to WRITE with next_after = IDLE on its first EDIT cycle.
- Bus protocol: bus_ack while bus_req is low is ignored. bus_addr, bus_we and bus_wdata never change while bus_req is high.
- Reset mid-transaction: bus_req drops asynchronously. The RTC bus master must tolerate the abandoned request.

Optional Feature:
- Macro: RTC_EDIT_TIMEOUT_EN.
- Defined:
  - A CNT_W-bit counter clears on any button or edit_req pulse and counts in EDIT only.
  - On reaching TIMEOUT_CYCLES-1, the controller writes the current field and returns to IDLE, the same as edit_req.
  - The counter holds in LOAD/WRITE.
- Undefined: no counter; EDIT persists indefinitely.

Decomposition:
- Shared package rtc_pkg:
  - field index constants FLD_SEC..FLD_YEAR and NUM_FIELDS=6;
  - per-field BCD min/max constants;
  - the state enumeration.
- One sub-module, bcd_field_step: combinational; inputs value, field, up, down; outputs the wrapped next value and the sanitised load value.

Test Plan:
- Enter edit; LOAD acks bus_rdata=8'h59 for sec; btn_up -> edit_val=8'h00; edit_req -> write of 8'h00 at addr 8'h21, then IDLE.
- Hour field loaded with 8'h00; btn_down -> 8'h23. Month loaded with 8'h12; btn_up -> 8'h01. Min loaded with 8'h39; btn_up -> 8'h40.
- btn_next six times with immediate acks -> writes to 8'h21..8'h26, each followed by a read of the next field; field_sel wraps 5 -> 0.
- bus_rdata=8'h7A on the day field -> edit_val=8'h01. btn_up and btn_down together -> edit_val unchanged.
- edit_req during LOAD with ack delayed 5 cycles -> LOAD completes, one WRITE, then IDLE; no extra bus_req.
- Reset asserted while bus_req is high -> bus_req=0 at once, and all outputs hold 0 after release. With the macro defined and TIMEOUT_CYCLES=16, 16 idle EDIT cycles -> WRITE, then IDLE.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC edit controller:
// field indices, BCD ranges and controller states.
package rtc_pkg;

  localparam logic [2:0] FLD_SEC   = 3'd0;
  localparam logic [2:0] FLD_MIN   = 3'd1;
  localparam logic [2:0] FLD_HOUR  = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_MONTH = 3'd4;
  localparam logic [2:0] FLD_YEAR  = 3'd5;
  localparam int NUM_FIELDS = 6;

  localparam logic [7:0] SEC_MIN   = 8'h00;
  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] MIN_MIN   = 8'h00;
  localparam logic [7:0] MIN_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MIN  = 8'h00;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] DAY_MIN   = 8'h01;
  localparam logic [7:0] DAY_MAX   = 8'h31;
  localparam logic [7:0] MONTH_MIN = 8'h01;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] YEAR_MIN  = 8'h00;
  localparam logic [7:0] YEAR_MAX  = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EDIT,
    ST_WRITE
  } state_t;

  function automatic logic [7:0] fld_min(input logic [2:0] f);
    case (f)
      FLD_SEC:   fld_min = SEC_MIN;
      FLD_MIN:   fld_min = MIN_MIN;
      FLD_HOUR:  fld_min = HOUR_MIN;
      FLD_DAY:   fld_min = DAY_MIN;
      FLD_MONTH: fld_min = MONTH_MIN;
      default:   fld_min = YEAR_MIN;
    endcase
  endfunction

  function automatic logic [7:0] fld_max(input logic [2:0] f);
    case (f)
      FLD_SEC:   fld_max = SEC_MAX;
      FLD_MIN:   fld_max = MIN_MAX;
      FLD_HOUR:  fld_max = HOUR_MAX;
      FLD_DAY:   fld_max = DAY_MAX;
      FLD_MONTH: fld_max = MONTH_MAX;
      default:   fld_max = YEAR_MAX;
    endcase
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// BCD up/down step with per-field wrap, plus
// sanitising of a raw register value to the field range.
module bcd_field_step
  import rtc_pkg::*;
(
  input  logic [7:0] value_i,
  input  logic [2:0] field_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [7:0] next_val_o,
  output logic [7:0] load_val_o
);

  logic [3:0] lo;
  logic [3:0] hi;
  logic [7:0] mn;
  logic [7:0] mx;
  logic       bad;

  assign lo = value_i[3:0];
  assign hi = value_i[7:4];
  assign mn = fld_min(field_i);
  assign mx = fld_max(field_i);

  // Stepped value; simultaneous up and down cancel.
  always_comb begin
    next_val_o = value_i;
    if (up_i && !down_i) begin
      if (value_i >= mx)
        next_val_o = mn;
      else if (lo == 4'd9)
        next_val_o = {hi + 4'd1, 4'd0};
      else
        next_val_o = value_i + 8'd1;
    end else if (down_i && !up_i) begin
      if (value_i <= mn)
        next_val_o = mx;
      else if (lo == 4'd0)
        next_val_o = {hi - 4'd1, 4'd9};
      else
        next_val_o = value_i - 8'd1;
    end
  end

  // Non-BCD or out-of-range reads fall back to the field minimum.
  always_comb begin
    bad = (lo > 4'd9) || (hi > 4'd9) ||
          (value_i < mn) || (value_i > mx);
    load_val_o = bad ? mn : value_i;
  end

endmodule

// File: rtl/rtc_edit_ctrl.sv
// RTC time/date edit sequencer: read field, adjust, write back.
// Optional idle auto-exit enabled by RTC_EDIT_TIMEOUT_EN.
module rtc_edit_ctrl
  import rtc_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR      = 8'h21,
  parameter int          TIMEOUT_CYCLES = 1000000000,
  parameter int          CNT_W          = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit_req,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_ack,
  output logic       edit_active,
  output logic [2:0] field_sel,
  output logic [7:0] edit_val
);

  state_t     state_q, state_d;
  logic [2:0] field_q, field_d;
  logic [7:0] val_q, val_d;
  logic       to_load_q, to_load_d;
  logic       pend_q, pend_d;
  logic [7:0] step_in;
  logic [7:0] step_val;
  logic [7:0] load_val;
  logic       tmo;

  assign step_in = (state_q == ST_LOAD) ? bus_rdata : val_q;

  bcd_field_step u_step (
    .value_i    (step_in),
    .field_i    (field_q),
    .up_i       (btn_up),
    .down_i     (btn_down),
    .next_val_o (step_val),
    .load_val_o (load_val)
  );

`ifdef RTC_EDIT_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_pulse;

  assign any_pulse = edit_req | btn_next | btn_up | btn_down;
  assign tmo = (state_q == ST_EDIT) && !any_pulse &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: cleared by any pulse, advances only in EDIT.
  always_comb begin
    cnt_d = cnt_q;
    if (any_pulse)
      cnt_d = '0;
    else if (state_q == ST_EDIT)
      cnt_d = cnt_q + 1'b1;
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      field_q   <= 3'd0;
      val_q     <= 8'h00;
      to_load_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      val_q     <= val_d;
      to_load_q <= to_load_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    val_d     = val_q;
    to_load_d = to_load_q;
    pend_d    = pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (edit_req) begin
          state_d = ST_LOAD;
          field_d = FLD_SEC;
        end
      end
      ST_LOAD: begin
        if (edit_req) pend_d = 1'b1;
        if (bus_ack) begin
          val_d   = load_val;
          state_d = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (edit_req || pend_q || tmo) begin
          state_d   = ST_WRITE;
          to_load_d = 1'b0;
          pend_d    = 1'b0;
        end else if (btn_next) begin
          state_d   = ST_WRITE;
          to_load_d = 1'b1;
        end else begin
          val_d = step_val;
        end
      end
      ST_WRITE: begin
        if (edit_req) pend_d = 1'b1;
        if (bus_ack) begin
          if (to_load_q) begin
            state_d = ST_LOAD;
            field_d = (field_q == FLD_YEAR) ? FLD_SEC
                                            : field_q + 3'd1;
          end else begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; address and data only change with state.
  always_comb begin
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = 8'h00;
    bus_wdata   = 8'h00;
    edit_active = (state_q != ST_IDLE);
    unique case (state_q)
      ST_LOAD: begin
        bus_req  = 1'b1;
        bus_addr = BASE_ADDR + {5'd0, field_q};
      end
      ST_WRITE: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = BASE_ADDR + {5'd0, field_q};
        bus_wdata = val_q;
      end
      default: ;
    endcase
  end

  assign field_sel = field_q;
  assign edit_val  = val_q;

endmodule
